// File: rtl/cic_decim_ctrl.sv
// Sequencing controller for a CIC decimator: handshakes input samples, enables the
// integrators, steps the comb chain once per decimated sample and holds the result.
module cic_decim_ctrl #(
  parameter int STAGES = 3,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [CNT_W-1:0]  cfg_r,
  input  logic              cfg_load,
  input  logic              stop,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              integ_ena,
  output logic              filt_clr,
  output logic [STAGES-1:0] comb_ena,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  phase,
  output logic              cfg_err
);

  localparam int SW = (STAGES > 1) ? $clog2(STAGES) : 1;
  localparam logic [SW-1:0] LAST_STAGE = SW'(STAGES - 1);

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    RUN,
    COMB,
    HOLD
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  ratio_q, ratio_d;
  logic [CNT_W-1:0]  pend_q, pend_d;
  logic              pend_vld_q, pend_vld_d;
  logic [CNT_W-1:0]  phase_q, phase_d;
  logic [SW-1:0]     stage_q, stage_d;
  logic [STAGES-1:0] comb_ena_q, comb_ena_d;
  logic [STAGES-1:0] stage_hit;
  logic              comb_go;
  logic              filt_clr_q, filt_clr_d;
  logic              out_valid_q, out_valid_d;
  logic              cfg_err_q, cfg_err_d;

  logic accept;
  logic last_sample;
  logic cfg_zero;
  logic cfg_good;

  // stop gates the handshake combinationally so an aborted cycle never accepts a sample
  assign in_ready    = (state_q == RUN) && !stop;
  assign accept      = in_valid && in_ready;
  assign last_sample = (phase_q == (ratio_q - CNT_W'(1)));
  assign cfg_zero    = cfg_load && !stop && (cfg_r == '0);
  assign cfg_good    = cfg_load && !stop && (cfg_r != '0);

  always_comb begin
    state_d     = state_q;
    ratio_d     = ratio_q;
    pend_d      = pend_q;
    pend_vld_d  = pend_vld_q;
    phase_d     = phase_q;
    stage_d     = stage_q;
    comb_go     = 1'b0;
    filt_clr_d  = 1'b0;
    out_valid_d = out_valid_q;
    cfg_err_d   = cfg_zero;

    if (stop) begin
      state_d     = IDLE;
      phase_d     = '0;
      stage_d     = '0;
      pend_vld_d  = 1'b0;
      out_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (cfg_good) begin
            ratio_d    = cfg_r;
            filt_clr_d = 1'b1;
            state_d    = CLR;
          end
        end
        CLR: begin
          phase_d = '0;
          state_d = RUN;
        end
        RUN: begin
          if (accept) begin
            if (last_sample) begin
              phase_d = '0;
              stage_d = '0;
              comb_go = 1'b1;
              state_d = COMB;
              // a pending ratio takes effect only from the period that starts after this one
              if (pend_vld_q) begin
                ratio_d = pend_q;
              end
              pend_vld_d = 1'b0;
            end else begin
              phase_d = phase_q + CNT_W'(1);
            end
          end
        end
        COMB: begin
          if (stage_q == LAST_STAGE) begin
            out_valid_d = 1'b1;
            state_d     = HOLD;
          end else begin
            stage_d = stage_q + SW'(1);
            comb_go = 1'b1;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid_d = 1'b0;
            state_d     = RUN;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase

      // evaluated after the COMB-entry swap so a same-cycle load queues for the next period
      if (cfg_good && (state_q != IDLE)) begin
        pend_d     = cfg_r;
        pend_vld_d = 1'b1;
      end
    end
  end

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage_dec
    assign stage_hit[gi] = (stage_d == SW'(gi));
  end

  assign comb_ena_d = comb_go ? stage_hit : '0;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      ratio_q     <= CNT_W'(1);
      pend_q      <= '0;
      pend_vld_q  <= 1'b0;
      phase_q     <= '0;
      stage_q     <= '0;
      comb_ena_q  <= '0;
      filt_clr_q  <= 1'b0;
      out_valid_q <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ratio_q     <= ratio_d;
      pend_q      <= pend_d;
      pend_vld_q  <= pend_vld_d;
      phase_q     <= phase_d;
      stage_q     <= stage_d;
      comb_ena_q  <= comb_ena_d;
      filt_clr_q  <= filt_clr_d;
      out_valid_q <= out_valid_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  assign integ_ena = accept;
  assign filt_clr  = filt_clr_q;
  assign comb_ena  = comb_ena_q;
  assign out_valid = out_valid_q;
  assign phase     = phase_q;
  assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_cic_decim_ctrl.sv
// Bench for cic_decim_ctrl: directed vector table, corner-case sequences and a
// randomized run checked against a timer-based behavioural model.
module tb_cic_decim_ctrl;

  localparam int STAGES = 3;
  localparam int CNT_W  = 16;

  logic              clock = 1'b0;
  logic              reset_n;
  logic [CNT_W-1:0]  cfg_r;
  logic              cfg_load;
  logic              stop;
  logic              in_valid;
  logic              in_ready;
  logic              integ_ena;
  logic              filt_clr;
  logic [STAGES-1:0] comb_ena;
  logic              out_valid;
  logic              out_ready;
  logic [CNT_W-1:0]  phase;
  logic              cfg_err;

  cic_decim_ctrl #(.STAGES(STAGES), .CNT_W(CNT_W)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .cfg_r    (cfg_r),
    .cfg_load (cfg_load),
    .stop     (stop),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .integ_ena(integ_ena),
    .filt_clr (filt_clr),
    .comb_ena (comb_ena),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .phase    (phase),
    .cfg_err  (cfg_err)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Model: mode 0 idle / 1 clearing / 2 streaming; m_since = cycles since the
  // decimating accept (-1 while collecting samples), >= STAGES means result held.
  int m_mode, m_samples, m_R, m_pend, m_since;
  bit m_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_samples = 0; m_R = 1; m_pend = 0; m_since = -1; m_err = 1'b0;
  endtask

  task automatic compare_model();
    logic       e_ir;
    logic [2:0] e_comb;
    e_ir   = (m_mode == 2) && (m_since < 0) && !stop;
    e_comb = (m_since >= 0 && m_since < STAGES) ? 3'(1 << m_since) : 3'b000;
    chk("m_in_ready", in_ready, e_ir);
    chk("m_integ_ena", integ_ena, e_ir & in_valid);
    chk("m_filt_clr", filt_clr, m_mode == 1);
    chk("m_comb_ena", comb_ena, e_comb);
    chk("m_out_valid", out_valid, m_since >= STAGES);
    chk("m_phase", phase, m_samples);
    chk("m_cfg_err", cfg_err, m_err);
  endtask

  task automatic model_update();
    bit good;
    int mode_before;
    good        = cfg_load && !stop && (cfg_r != 0);
    mode_before = m_mode;
    m_err       = cfg_load && !stop && (cfg_r == 0);
    if (stop) begin
      m_mode = 0; m_samples = 0; m_since = -1; m_pend = 0;
    end else begin
      case (m_mode)
        0: if (good) begin m_R = int'(cfg_r); m_mode = 1; end
        1: begin m_mode = 2; m_samples = 0; end
        default: begin
          if (m_since < 0) begin
            if (in_valid) begin
              m_samples++;
              if (m_samples == m_R) begin
                m_samples = 0;
                m_since   = 0;
                if (m_pend != 0) begin m_R = m_pend; m_pend = 0; end
              end
            end
          end else if (m_since < STAGES) begin
            m_since++;
          end else if (out_ready) begin
            m_since = -1;
          end
        end
      endcase
      if (good && mode_before != 0) m_pend = int'(cfg_r);
    end
  endtask

  task automatic step();
    @(negedge clock);
    compare_model();
    @(posedge clock);
    model_update();
    #1;
    cyc++;
  endtask

  task automatic set_in(input logic ld, input logic [CNT_W-1:0] r, input logic iv,
                        input logic ordy, input logic stp);
    cfg_load = ld; cfg_r = r; in_valid = iv; out_ready = ordy; stop = stp;
  endtask

  // Assert reset asynchronously between edges, check outputs clear at once, release after an edge.
  task automatic do_reset(input string tag);
    set_in(1'b0, '0, 1'b0, 1'b0, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    chk({tag, "_rst_filt_clr"}, filt_clr, 1'b0);
    chk({tag, "_rst_comb_ena"}, comb_ena, 3'b000);
    chk({tag, "_rst_out_valid"}, out_valid, 1'b0);
    chk({tag, "_rst_phase"}, phase, 16'd0);
    chk({tag, "_rst_cfg_err"}, cfg_err, 1'b0);
    chk({tag, "_rst_in_ready"}, in_ready, 1'b0);
    model_reset();
    @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  typedef struct {
    logic        ld;
    logic [15:0] r;
    logic        iv;
    logic        ordy;
    logic        e_ir;
    logic        e_ig;
    logic        e_filt;
    logic [2:0]  e_comb;
    logic        e_ov;
    logic [15:0] e_ph;
    logic        e_err;
  } vec_t;

  function automatic vec_t mk(input logic ld, input logic [15:0] r, input logic iv,
                              input logic ordy, input logic ir, input logic ig,
                              input logic filt, input logic [2:0] comb, input logic ov,
                              input logic [15:0] ph, input logic err);
    vec_t v;
    v.ld = ld; v.r = r; v.iv = iv; v.ordy = ordy; v.e_ir = ir; v.e_ig = ig;
    v.e_filt = filt; v.e_comb = comb; v.e_ov = ov; v.e_ph = ph; v.e_err = err;
    return v;
  endfunction

  localparam int NV = 19;
  vec_t vt[NV];

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int n, cnt;

    //            ld  r   iv ordy ir ig filt comb    ov ph err
    vt[0]  = mk(1, 0, 1, 1, 0, 0, 0, 3'b000, 0, 0, 0);
    vt[1]  = mk(1, 4, 1, 1, 0, 0, 0, 3'b000, 0, 0, 1);
    vt[2]  = mk(0, 0, 1, 1, 0, 0, 1, 3'b000, 0, 0, 0);
    vt[3]  = mk(0, 0, 1, 1, 1, 1, 0, 3'b000, 0, 0, 0);
    vt[4]  = mk(0, 0, 1, 1, 1, 1, 0, 3'b000, 0, 1, 0);
    vt[5]  = mk(0, 0, 1, 1, 1, 1, 0, 3'b000, 0, 2, 0);
    vt[6]  = mk(0, 0, 1, 1, 1, 1, 0, 3'b000, 0, 3, 0);
    vt[7]  = mk(0, 0, 1, 1, 0, 0, 0, 3'b001, 0, 0, 0);
    vt[8]  = mk(0, 0, 1, 1, 0, 0, 0, 3'b010, 0, 0, 0);
    vt[9]  = mk(0, 0, 1, 1, 0, 0, 0, 3'b100, 0, 0, 0);
    vt[10] = mk(0, 0, 1, 1, 0, 0, 0, 3'b000, 1, 0, 0);
    vt[11] = mk(0, 0, 1, 1, 1, 1, 0, 3'b000, 0, 0, 0);
    vt[12] = mk(0, 0, 1, 1, 1, 1, 0, 3'b000, 0, 1, 0);
    vt[13] = mk(0, 0, 1, 1, 1, 1, 0, 3'b000, 0, 2, 0);
    vt[14] = mk(0, 0, 1, 1, 1, 1, 0, 3'b000, 0, 3, 0);
    vt[15] = mk(0, 0, 1, 1, 0, 0, 0, 3'b001, 0, 0, 0);
    vt[16] = mk(0, 0, 1, 1, 0, 0, 0, 3'b010, 0, 0, 0);
    vt[17] = mk(0, 0, 1, 1, 0, 0, 0, 3'b100, 0, 0, 0);
    vt[18] = mk(0, 0, 1, 1, 0, 0, 0, 3'b000, 1, 0, 0);

    reset_n = 1'b1;
    set_in(1'b0, '0, 1'b0, 1'b0, 1'b0);
    @(posedge clock);
    #1;
    do_reset("init");

    // Table: illegal load, then R=4 with a continuous source and ready consumer.
    for (int i = 0; i < NV; i++) begin
      set_in(vt[i].ld, vt[i].r, vt[i].iv, vt[i].ordy, 1'b0);
      @(negedge clock);
      chk($sformatf("tv%0d_in_ready", i), in_ready, vt[i].e_ir);
      chk($sformatf("tv%0d_integ_ena", i), integ_ena, vt[i].e_ig);
      chk($sformatf("tv%0d_filt_clr", i), filt_clr, vt[i].e_filt);
      chk($sformatf("tv%0d_comb_ena", i), comb_ena, vt[i].e_comb);
      chk($sformatf("tv%0d_out_valid", i), out_valid, vt[i].e_ov);
      chk($sformatf("tv%0d_phase", i), phase, vt[i].e_ph);
      chk($sformatf("tv%0d_cfg_err", i), cfg_err, vt[i].e_err);
      compare_model();
      @(posedge clock);
      model_update();
      #1;
      cyc++;
    end

    // R=1: one decimated output every STAGES+2 cycles.
    do_reset("r1");
    set_in(1'b1, 16'd1, 1'b1, 1'b1, 1'b0);
    step();
    cfg_load = 1'b0;
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin step(); n++; end
    chk("r1_first_out_valid", out_valid, 1'b1);
    step();
    cnt = 1;
    while (out_valid !== 1'b1 && cnt < 20) begin
      chk("r1_phase_zero", phase, 16'd0);
      step();
      cnt++;
    end
    chk("r1_out_period", cnt, STAGES + 2);

    // Backpressure: consumer stalls 10 cycles in HOLD.
    do_reset("bp");
    set_in(1'b1, 16'd2, 1'b1, 1'b0, 1'b0);
    step();
    cfg_load = 1'b0;
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin step(); n++; end
    chk("bp_reach_hold", out_valid, 1'b1);
    for (int k = 0; k < 10; k++) begin
      chk("bp_out_valid", out_valid, 1'b1);
      chk("bp_in_ready", in_ready, 1'b0);
      chk("bp_integ_ena", integ_ena, 1'b0);
      chk("bp_comb_ena", comb_ena, 3'b000);
      step();
    end
    out_ready = 1'b1;
    step();
    chk("bp_release_in_ready", in_ready, 1'b1);
    chk("bp_release_out_valid", out_valid, 1'b0);

    // Ratio change mid-period: R=4 period finishes with 4 samples, next takes 8.
    do_reset("rchg");
    set_in(1'b1, 16'd4, 1'b1, 1'b1, 1'b0);
    step();
    cfg_load = 1'b0;
    n = 0;
    while (phase !== 16'd2 && n < 20) begin step(); n++; end
    chk("rchg_reach_phase2", phase, 16'd2);
    cfg_load = 1'b1;
    cfg_r    = 16'd8;
    cnt = 0;
    n   = 0;
    while (comb_ena !== 3'b001 && n < 30) begin
      if (integ_ena === 1'b1) cnt++;
      step();
      cfg_load = 1'b0;
      n++;
    end
    chk("rchg_old_period_tail", cnt, 2);
    step();
    cnt = 0;
    n   = 0;
    while (comb_ena !== 3'b001 && n < 40) begin
      if (integ_ena === 1'b1) cnt++;
      step();
      n++;
    end
    chk("rchg_new_period_len", cnt, 8);

    // stop during COMB stage 1.
    do_reset("stop");
    set_in(1'b1, 16'd3, 1'b1, 1'b1, 1'b0);
    step();
    cfg_load = 1'b0;
    n = 0;
    while (comb_ena !== 3'b010 && n < 20) begin step(); n++; end
    chk("stop_reach_s1", comb_ena, 3'b010);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("stop_comb_ena", comb_ena, 3'b000);
    chk("stop_out_valid", out_valid, 1'b0);
    chk("stop_phase", phase, 16'd0);
    chk("stop_idle_in_ready", in_ready, 1'b0);
    step();
    chk("stop_stays_idle", in_ready, 1'b0);

    // Asynchronous reset in the middle of RUN.
    set_in(1'b1, 16'd5, 1'b1, 1'b1, 1'b0);
    step();
    cfg_load = 1'b0;
    n = 0;
    while (phase !== 16'd3 && n < 20) begin step(); n++; end
    chk("arst_reach_phase3", phase, 16'd3);
    do_reset("arst");
    step();
    chk("arst_idle_in_ready", in_ready, 1'b0);

    // Randomized traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      cfg_load  = ($urandom_range(0, 25) == 0);
      cfg_r     = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 6));
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      stop      = ($urandom_range(0, 150) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
